// File: rtl/magnetron_sr_bank_if.sv
`default_nettype none
// ============================================================================
// magnetron_sr_bank_if : request/state bundle for the magnetron SR bank
// Rev 1.0
// ============================================================================
interface magnetron_sr_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] r;
  logic                clr;
  logic [CHANNELS-1:0] q;
  logic [CHANNELS-1:0] qn;
  logic [CHANNELS-1:0] changed;
  logic [CHANNELS-1:0] conflict;

  modport master (
    output s, r, clr,
    input  q, qn, changed, conflict
  );

  modport slave (
    input  s, r, clr,
    output q, qn, changed, conflict
  );
endinterface
`default_nettype wire

// File: rtl/magnetron_sr_bank.sv
`default_nettype none
// ============================================================================
// magnetron_sr_bank : debounced multi-channel set/reset register bank
// Rev 1.0
// ============================================================================
module magnetron_sr_bank #(
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 3,
  parameter int MODE     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  magnetron_sr_bank_if.slave bus
);

  localparam int            CW    = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] C_DEB = CW'(DEBOUNCE);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  if ((MODE < 0) || (MODE > 3)) begin : g_bad_mode
    $error("magnetron_sr_bank: MODE must be 0..3");
  end
  if ((DEBOUNCE < 1) || (CHANNELS < 1)) begin : g_bad_size
    $error("magnetron_sr_bank: DEBOUNCE and CHANNELS must be >= 1");
  end

  logic [CHANNELS-1:0][CW-1:0] s_cnt_q, s_cnt_d;
  logic [CHANNELS-1:0][CW-1:0] r_cnt_q, r_cnt_d;
  logic [CHANNELS-1:0]         q_q, q_d;
  logic [CHANNELS-1:0]         changed_q, changed_d;
  logic [CHANNELS-1:0]         conflict_q, conflict_d;
  logic [CHANNELS-1:0]         both_prev_q, both_prev_d;
  logic [CHANNELS-1:0]         sq, rq, both, q_next;

  always_comb begin
    s_cnt_d = s_cnt_q;
    r_cnt_d = r_cnt_q;
    sq      = '0;
    rq      = '0;
    both    = '0;
    q_next  = q_q;
    for (int i = 0; i < CHANNELS; i++) begin
      // Qualification comes only from the registered count, never the raw pin.
      sq[i]   = (s_cnt_q[i] == C_DEB);
      rq[i]   = (r_cnt_q[i] == C_DEB);
      both[i] = sq[i] & rq[i];

      if (!bus.s[i])   s_cnt_d[i] = '0;
      else if (!sq[i]) s_cnt_d[i] = s_cnt_q[i] + C_ONE;
      if (!bus.r[i])   r_cnt_d[i] = '0;
      else if (!rq[i]) r_cnt_d[i] = r_cnt_q[i] + C_ONE;

      if (sq[i] && !rq[i]) begin
        q_next[i] = 1'b1;
      end else if (rq[i] && !sq[i]) begin
        q_next[i] = 1'b0;
      end else if (both[i]) begin
        case (MODE)
          0:       q_next[i] = 1'b0;
          1:       q_next[i] = 1'b1;
          3:       if (!both_prev_q[i]) q_next[i] = ~q_q[i];
          default: q_next[i] = q_q[i];
        endcase
      end
    end

    if (bus.clr) begin
      // Clear wins over everything; changed flags only channels that were set.
      q_d         = '0;
      s_cnt_d     = '0;
      r_cnt_d     = '0;
      both_prev_d = '0;
      conflict_d  = '0;
      changed_d   = q_q;
    end else begin
      q_d         = q_next;
      both_prev_d = both;
      conflict_d  = both & ~both_prev_q;
      changed_d   = q_next ^ q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt_q     <= '0;
      r_cnt_q     <= '0;
      q_q         <= '0;
      changed_q   <= '0;
      conflict_q  <= '0;
      both_prev_q <= '0;
    end else begin
      s_cnt_q     <= s_cnt_d;
      r_cnt_q     <= r_cnt_d;
      q_q         <= q_d;
      changed_q   <= changed_d;
      conflict_q  <= conflict_d;
      both_prev_q <= both_prev_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.qn       = ~q_q;
  assign bus.changed  = changed_q;
  assign bus.conflict = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_magnetron_sr_bank.sv
`default_nettype none
// ============================================================================
// tb_magnetron_sr_bank : scoreboard bench running all four MODE variants
// Rev 1.0
// ============================================================================
module tb_magnetron_sr_bank;
  localparam int CH  = 4;
  localparam int DEB = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] s     = '0;
  logic [CH-1:0] r     = '0;
  logic          clr   = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  magnetron_sr_bank_if #(.CHANNELS(CH)) bus0 ();
  magnetron_sr_bank_if #(.CHANNELS(CH)) bus1 ();
  magnetron_sr_bank_if #(.CHANNELS(CH)) bus2 ();
  magnetron_sr_bank_if #(.CHANNELS(CH)) bus3 ();

  assign bus0.s = s;  assign bus0.r = r;  assign bus0.clr = clr;
  assign bus1.s = s;  assign bus1.r = r;  assign bus1.clr = clr;
  assign bus2.s = s;  assign bus2.r = r;  assign bus2.clr = clr;
  assign bus3.s = s;  assign bus3.r = r;  assign bus3.clr = clr;

  magnetron_sr_bank #(.CHANNELS(CH), .DEBOUNCE(DEB), .MODE(0)) u_m0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  magnetron_sr_bank #(.CHANNELS(CH), .DEBOUNCE(DEB), .MODE(1)) u_m1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  magnetron_sr_bank #(.CHANNELS(CH), .DEBOUNCE(DEB), .MODE(2)) u_m2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  magnetron_sr_bank #(.CHANNELS(CH), .DEBOUNCE(DEB), .MODE(3)) u_m3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  logic [CH-1:0] dq [4];
  logic [CH-1:0] dqn[4];
  logic [CH-1:0] dch[4];
  logic [CH-1:0] dcf[4];
  assign dq[0] = bus0.q;  assign dqn[0] = bus0.qn;  assign dch[0] = bus0.changed;  assign dcf[0] = bus0.conflict;
  assign dq[1] = bus1.q;  assign dqn[1] = bus1.qn;  assign dch[1] = bus1.changed;  assign dcf[1] = bus1.conflict;
  assign dq[2] = bus2.q;  assign dqn[2] = bus2.qn;  assign dch[2] = bus2.changed;  assign dcf[2] = bus2.conflict;
  assign dq[3] = bus3.q;  assign dqn[3] = bus3.qn;  assign dch[3] = bus3.changed;  assign dcf[3] = bus3.conflict;

  // Reference model: run lengths of consecutive high samples per raw input.
  int            run_s[CH];
  int            run_r[CH];
  logic [CH-1:0] mq [4];
  logic [CH-1:0] mbp[4];

  typedef struct {
    int            mode;
    logic [CH-1:0] q;
    logic [CH-1:0] ch;
    logic [CH-1:0] cf;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      run_s[i] = 0;
      run_r[i] = 0;
    end
    for (int m = 0; m < 4; m++) begin
      mq[m]  = '0;
      mbp[m] = '0;
    end
  endtask

  task automatic predict();
    logic [CH-1:0] sq, rq, both, nq;
    exp_t e;
    for (int i = 0; i < CH; i++) begin
      sq[i] = (run_s[i] >= DEB);
      rq[i] = (run_r[i] >= DEB);
    end
    both = sq & rq;
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < CH; i++) begin
        if (clr)            nq[i] = 1'b0;
        else if (both[i])   nq[i] = (m == 0) ? 1'b0 :
                                    (m == 1) ? 1'b1 :
                                    ((m == 3) && !mbp[m][i]) ? ~mq[m][i] : mq[m][i];
        else if (sq[i])     nq[i] = 1'b1;
        else if (rq[i])     nq[i] = 1'b0;
        else                nq[i] = mq[m][i];
      end
      e.mode = m;
      e.q    = nq;
      e.ch   = nq ^ mq[m];
      e.cf   = clr ? '0 : (both & ~mbp[m]);
      sb.push_back(e);
      mq[m]  = nq;
      mbp[m] = clr ? '0 : both;
    end
    for (int i = 0; i < CH; i++) begin
      run_s[i] = (clr || !s[i]) ? 0 : run_s[i] + 1;
      run_r[i] = (clr || !r[i]) ? 0 : run_r[i] + 1;
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s/m%0d/q", tag, e.mode),        dq[e.mode],  e.q);
      chk($sformatf("%s/m%0d/qn", tag, e.mode),       dqn[e.mode], ~e.q);
      chk($sformatf("%s/m%0d/changed", tag, e.mode),  dch[e.mode], e.ch);
      chk($sformatf("%s/m%0d/conflict", tag, e.mode), dcf[e.mode], e.cf);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nch, ncf;
    logic [5:0] pat;
    logic [CH-1:0] exp_q2;

    // 1. reset value and set latency
    model_reset();
    s = 4'b1111;
    @(posedge clk); @(posedge clk); #1;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst/m%0d/q", m),        dq[m],  4'b0000);
      chk($sformatf("rst/m%0d/qn", m),       dqn[m], 4'b1111);
      chk($sformatf("rst/m%0d/changed", m),  dch[m], 4'b0000);
      chk($sformatf("rst/m%0d/conflict", m), dcf[m], 4'b0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s     = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      step("t1");
      chk($sformatf("t1_pre_e%0d", k), dq[0], 4'b0000);
    end
    step("t1");
    chk("t1_set_q", dq[0], 4'b0001);
    chk("t1_set_changed", dch[0], 4'b0001);
    step("t1");
    chk("t1_changed_once", dch[0], 4'b0000);
    step("t1");

    // 2. bounce rejection
    s   = 4'b0000;
    pat = 6'b111011;
    for (int k = 0; k < 6; k++) begin
      s[1] = pat[k];
      step("t2");
      chk($sformatf("t2_bounce_e%0d", k + 1), {3'b000, dq[0][1]}, 4'b0000);
    end
    s[1] = 1'b0;
    step("t2");
    chk("t2_set_e7", {3'b000, dq[0][1]}, 4'b0001);
    r[1] = 1'b1;
    step("t2"); step("t2");
    r[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("t2");
      chk("t2_short_reset", {3'b000, dq[0][1]}, 4'b0001);
    end

    // 3. conflict resolution per mode on channel 2
    s[2] = 1'b1; r[2] = 1'b1;
    step("t3"); step("t3"); step("t3"); step("t3");
    exp_q2 = 4'b1010;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t3_m%0d_q2", m),        {3'b000, dq[m][2]},  {3'b000, exp_q2[m]});
      chk($sformatf("t3_m%0d_conflict2", m), {3'b000, dcf[m][2]}, 4'b0001);
    end
    for (int k = 0; k < 10; k++) begin
      step("t3");
      chk("t3_m3_hold", {3'b000, dq[3][2]}, 4'b0001);
    end
    s = '0; r = '0;
    step("t3"); step("t3");

    // 4. toggle re-arm on channel 3, mode 3
    nch = 0; ncf = 0;
    for (int k = 0; k < 13; k++) begin
      s[3] = (k != 5) && (k < 11);
      r[3] = s[3];
      step("t4");
      nch += int'(dch[3][3]);
      ncf += int'(dcf[3][3]);
    end
    chk("t4_changed_pulses", CH'(nch), 4'd2);
    chk("t4_conflict_pulses", CH'(ncf), 4'd2);
    chk("t4_final_q3", {3'b000, dq[3][3]}, 4'b0000);

    // 5. clr priority
    s = 4'b1000; r = 4'b0001;
    for (int k = 0; k < 4; k++) step("t5");
    chk("t5_setup_q", dq[0], 4'b1010);
    s = 4'b0001; r = '0;
    for (int k = 0; k < 3; k++) step("t5");
    clr = 1'b1;
    step("t5");
    chk("t5_clr_q", dq[0], 4'b0000);
    chk("t5_clr_changed", dch[0], 4'b1010);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("t5");
      chk("t5_recount", dq[0], 4'b0000);
    end
    step("t5");
    chk("t5_reset_after", dq[0], 4'b0001);

    // 6. async reset mid-count
    s = 4'b0110; r = 4'b0001;
    for (int k = 0; k < 4; k++) step("t6");
    s = '0; r = '0;
    step("t6");
    s = 4'b1000;
    step("t6"); step("t6");
    chk("t6_pre_q", dq[0], 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t6_async/m%0d/q", m),  dq[m],  4'b0000);
      chk($sformatf("t6_async/m%0d/qn", m), dqn[m], 4'b1111);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("t6");
      chk("t6_recount", dq[0], 4'b0000);
    end
    step("t6");
    chk("t6_set_after", dq[0], 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/magnetron_sr_bank.md
# magnetron_sr_bank

Parametrised, clocked multi-channel set/reset register bank with per-input debounce, selectable conflict-resolution mode and per-channel change/conflict event pulses. It is the synchronous successor to the asynchronous single-bit SR latch in the magnetron control path. It holds door-interlock, cook-request and fault-latch states for the magnetron controller, and it filters contact bounce before any state changes.

## Interface
Parameters:
- CHANNELS, 4, number of independent SR channels (≥1)
- DEBOUNCE, 3, consecutive sampled-high cycles before an s/r input is qualified (≥1)
- MODE, 0, action when both s and r are qualified on a channel: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle

Ports:
- clk  in  1  single system clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- s  in  CHANNELS  raw set request per channel, active high
- r  in  CHANNELS  raw reset request per channel, active high
- clr  in  1  synchronous clear of all channels, active high
- q  out  CHANNELS  registered channel state
- qn  out  CHANNELS  bitwise complement of q
- changed  out  CHANNELS  one-cycle pulse, high in the cycle after q[i] changed
- conflict  out  CHANNELS  one-cycle pulse when s and r on channel i first become simultaneously qualified

## Operation
- Each s[i] and r[i] has its own filter counter cnt, of width clog2(DEBOUNCE+1). On each edge:
  - raw input low: cnt <= 0
  - raw input high and cnt<DEBOUNCE: cnt <= cnt+1
  - raw input high and cnt=DEBOUNCE: saturate
- Qualified level sq[i]/rq[i] = (cnt==DEBOUNCE). It is derived from the registered count only, with no combinational path from the raw inputs.
- Next state per channel, evaluated from sq/rq:
  - sq only: q <= 1
  - rq only: q <= 0
  - neither: hold
  - both, MODE 0: q <= 0
  - both, MODE 1: q <= 1
  - both, MODE 2: hold
  - both, MODE 3: q <= ~q, only on the first cycle of "both" (edge-detected via a registered both_d[i]); hold while "both" persists
- Set and reset are level actions. A held qualified s keeps q=1 with no further changed pulses.
- conflict[i] <= both[i] & ~both_d[i], in all modes.
- changed[i] <= (q_next[i] != q[i]), registered in the same edge as q.
- clr has highest priority on each edge. It forces:
  - q <= 0 and all cnt <= 0
  - both_d <= 0 and conflict <= 0
  - changed[i] <= q[i], so a pulse appears only for channels that were set.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- Values of MODE other than 0–3 are illegal and are rejected by an elaboration-time check.

## Timing
- Reset (rst_n low, asynchronous, immediate): q=0, qn=all ones, changed=0, conflict=0, all cnt=0, both_d=0. Release is synchronised by the system; the first active edge follows deassertion.
- Latency from raw to q: an input sampled high at DEBOUNCE consecutive edges E1..E_D gives q updated at edge E_(D+1). For DEBOUNCE=3, s high before edge 1 gives q=1 after edge 4.
- A raw pulse of exactly DEBOUNCE sampled cycles suffices. The input may drop before E_(D+1) and q still updates at E_(D+1), because qualification is registered.
- A raw pulse of DEBOUNCE−1 cycles, or any single low sample mid-count, restarts the count and causes no q change.
- Deassertion is immediate: raw low at edge k clears cnt at k, so sq is low from cycle k onward.
- changed and conflict are high for exactly one cycle, aligned with the first cycle the new q is visible.
- Reset mid-count discards the partial count. clr mid-count does the same, synchronously.
- qn is combinational from q, with zero added latency.

## Test plan
Configuration for all scenarios: CHANNELS=4, DEBOUNCE=3.
1. Reset value and set latency (MODE 0): assert rst_n=0 with s=4'b1111, then release → q=0 and qn=4'b1111 during reset. With s[0]=1 held from edge 1, q=4'b0001 after edge 4 and changed=4'b0001 for one cycle only.
2. Bounce rejection: s[1] pattern 1,1,0,1,1,1 across edges 1–6 → q[1]=0 through edge 6 and q[1]=1 after edge 7. Separately, a 2-cycle pulse on r[1] while q[1]=1 → q[1] stays 1.
3. Conflict modes: hold s[2] and r[2] high from the same edge with q[2]=0 initially. After edge 4, conflict[2] pulses once, and q[2] follows MODE:
   - MODE 0: q[2]=0
   - MODE 1: q[2]=1
   - MODE 2: q[2]=0 (held)
   - MODE 3: q[2]=1, then stays 1 for 10 further cycles of "both"
4. Toggle re-arm (MODE 3): both high for 5 cycles, then both low for 1 cycle, then both high again → q toggles 0→1 and later 1→0. This gives two changed pulses and two conflict pulses.
5. clr priority: q=4'b1010 with s[0] qualified on the same edge as clr=1 → q=4'b0000 and changed=4'b1010. q[0] needs another 3 qualified cycles plus 1 edge before it sets.
6. Async reset mid-operation: drop rst_n between edges while cnt=2 and q=4'b0110 → q=0 immediately. After release, an input needs a full 3-cycle count before it can set q.
